// File: rtl/itof_pipe.sv
// itof_pipe: pipelined 32-bit integer to IEEE-754 single-precision converter.
// It supports signed or unsigned operands, round-to-nearest-even or
// round-toward-zero, an inexact flag, and valid/ready flow control.
//
// Handshake: an input transfers on a rising edge where in_valid & in_ready.
// An output transfers on a rising edge where out_valid & out_ready.
// in_ready is the global advance enable (~out_valid | out_ready). It is purely
// combinational from the output stage and out_ready. Every stage moves
// together or holds together, so bubbles stay in place.
//
// Stage split for NSTAGE >= 2:
//   stage 0 holds the sign and magnitude,
//   stage 1 holds the packed result after LZC, normalise and round,
//   stages 2.. are plain delay registers.
// For NSTAGE == 1 the whole conversion sits in front of the single output
// register.
module itof_pipe #(
    parameter int NSTAGE = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic        uns,
    input  logic        rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        inexact
);

    logic        en;
    logic        in_s;
    logic [31:0] in_m;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Sign and magnitude. Signed 0x80000000 negates to itself, which is 2^31 unsigned.
    assign in_s = ~uns & x[31];
    assign in_m = in_s ? (32'd0 - x) : x;

    // Returns {inexact, y} for a sign/magnitude pair; rz=1 selects truncation.
    function automatic logic [32:0] convert(input logic s, input logic [31:0] m,
                                            input logic rz);
        logic [4:0]  p;
        logic [31:0] norm;
        logic [22:0] mant;
        logic        g;
        logic        st;
        logic        inc;
        logic [23:0] sum;
        logic [7:0]  e;
        p = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) p = i[4:0];
        end
        // Left-align the leading one at bit 31; bits below bit 0 zero-fill.
        norm = m << (5'd31 - p);
        mant = norm[30:8];
        g    = norm[7];
        st   = |norm[6:0];
        inc  = ~rz & g & (st | mant[0]);
        sum  = {1'b0, mant} + {23'd0, inc};
        // A mantissa carry wraps the fraction to zero and bumps the exponent.
        e    = 8'd127 + {3'd0, p} + {7'd0, sum[23]};
        if (m == 32'd0) convert = 33'd0;
        else            convert = {g | st, s, e, sum[22:0]};
    endfunction

    generate
        if (NSTAGE == 1) begin : g_one
            logic        v_q;
            logic [31:0] y_q;
            logic        ix_q;
            logic [32:0] conv_d;

            assign conv_d = convert(in_s, in_m, rm);

            // Single output register that loads the full conversion on advance.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    v_q  <= 1'b0;
                    y_q  <= 32'h0;
                    ix_q <= 1'b0;
                end else if (en) begin
                    v_q <= in_valid;
                    if (in_valid) begin
                        y_q  <= conv_d[31:0];
                        ix_q <= conv_d[32];
                    end
                end
            end

            assign out_valid = v_q;
            assign y         = y_q;
            assign inexact   = ix_q;
        end else begin : g_multi
            logic        s0_v_q;
            logic        s0_s_q;
            logic [31:0] s0_m_q;
            logic        s0_rm_q;
            logic        r_v_q  [1:NSTAGE-1];
            logic [31:0] r_y_q  [1:NSTAGE-1];
            logic        r_ix_q [1:NSTAGE-1];
            logic [32:0] conv_d;

            assign conv_d = convert(s0_s_q, s0_m_q, s0_rm_q);

            // Stage 0 captures the sign, the magnitude and the rounding mode of an accepted input.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s0_v_q  <= 1'b0;
                    s0_s_q  <= 1'b0;
                    s0_m_q  <= 32'h0;
                    s0_rm_q <= 1'b0;
                end else if (en) begin
                    s0_v_q <= in_valid;
                    if (in_valid) begin
                        s0_s_q  <= in_s;
                        s0_m_q  <= in_m;
                        s0_rm_q <= rm;
                    end
                end
            end

            // Result stages: stage 1 takes the rounded result and later stages shift it along.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 1; k < NSTAGE; k++) begin
                        r_v_q[k]  <= 1'b0;
                        r_y_q[k]  <= 32'h0;
                        r_ix_q[k] <= 1'b0;
                    end
                end else if (en) begin
                    r_v_q[1] <= s0_v_q;
                    if (s0_v_q) begin
                        r_y_q[1]  <= conv_d[31:0];
                        r_ix_q[1] <= conv_d[32];
                    end
                    for (int k = 2; k < NSTAGE; k++) begin
                        r_v_q[k] <= r_v_q[k-1];
                        if (r_v_q[k-1]) begin
                            r_y_q[k]  <= r_y_q[k-1];
                            r_ix_q[k] <= r_ix_q[k-1];
                        end
                    end
                end
            end

            assign out_valid = r_v_q[NSTAGE-1];
            assign y         = r_y_q[NSTAGE-1];
            assign inexact   = r_ix_q[NSTAGE-1];
        end
    endgenerate

endmodule

// File: tb/tb_itof_pipe.sv
module tb_itof_pipe;

  localparam int NS = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [31:0] x;
  logic        uns;
  logic        rm;
  logic        out_ready;
  logic        out_ready_aux;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] y;
  logic        inexact;

  logic        ir_a [1:4];
  logic        ov_a [1:4];
  logic [31:0] y_a  [1:4];
  logic        ix_a [1:4];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] x;
    logic        u;
    logic        r;
    logic [31:0] y;
    logic        ix;
  } vec_t;

  always #5 clk = ~clk;

  itof_pipe #(.NSTAGE(NS)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .uns(uns), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .inexact(inexact)
  );

  itof_pipe #(.NSTAGE(1)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir_a[1]),
    .x(x), .uns(uns), .rm(rm), .out_valid(ov_a[1]), .out_ready(out_ready_aux),
    .y(y_a[1]), .inexact(ix_a[1])
  );

  itof_pipe #(.NSTAGE(3)) dut3 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir_a[3]),
    .x(x), .uns(uns), .rm(rm), .out_valid(ov_a[3]), .out_ready(out_ready_aux),
    .y(y_a[3]), .inexact(ix_a[3])
  );

  itof_pipe #(.NSTAGE(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir_a[4]),
    .x(x), .uns(uns), .rm(rm), .out_valid(ov_a[4]), .out_ready(out_ready_aux),
    .y(y_a[4]), .inexact(ix_a[4])
  );

  assign ir_a[2] = in_ready;
  assign ov_a[2] = out_valid;
  assign y_a[2]  = y;
  assign ix_a[2] = inexact;

  // Driver: present one vector at a negedge, then wait for the main DUT output.
  // Returns the result and the number of edges after acceptance.
  task automatic drive_vec(input logic [31:0] xv, input logic u, input logic r,
                           output logic [31:0] yo, output logic ixo, output int lat);
    in_valid = 1'b1;
    x = xv;
    uns = u;
    rm = r;
    @(negedge clk);
    in_valid = 1'b0;
    x = 32'hDEAD_BEEF;
    lat = 0;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    yo = y;
    ixo = inexact;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    in_valid = 1'b0;
    x = 32'h0;
    uns = 1'b0;
    rm = 1'b0;
    out_ready = 1'b1;
    out_ready_aux = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0 || y !== 32'h0 || inexact !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b y=%h inexact=%b required 0 00000000 0",
               out_valid, y, inexact);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Latency for NSTAGE 1..4: x=1 accepted at edge N should show at edge N+NSTAGE-1.
  task automatic test_latency;
    out_ready = 1'b1;
    in_valid = 1'b1;
    x = 32'd1;
    uns = 1'b0;
    rm = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int n = 1; n <= 4; n++) begin
        checks++;
        if (ov_a[n] !== (k == n - 1)) begin
          errors++;
          $display("FAIL latency_ns%0d_edge%0d: out_valid=%b required %b",
                   n, k, ov_a[n], (k == n - 1));
        end
        if (k == n - 1) begin
          checks++;
          if (y_a[n] !== 32'h3F800000 || ix_a[n] !== 1'b0) begin
            errors++;
            $display("FAIL latency_ns%0d_value: y=%h ix=%b required 3f800000 0",
                     n, y_a[n], ix_a[n]);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rounding;
    vec_t v [10];
    logic [31:0] yo;
    logic ixo;
    int lat;
    v = '{
      '{32'd16777217, 1'b0, 1'b0, 32'h4B800000, 1'b1},
      '{32'd16777217, 1'b0, 1'b1, 32'h4B800000, 1'b1},
      '{32'd16777219, 1'b0, 1'b0, 32'h4B800002, 1'b1},
      '{32'd16777219, 1'b0, 1'b1, 32'h4B800001, 1'b1},
      '{32'd16777221, 1'b0, 1'b0, 32'h4B800002, 1'b1},
      '{32'd16777218, 1'b0, 1'b0, 32'h4B800001, 1'b0},
      '{32'h7FFFFFFF, 1'b0, 1'b0, 32'h4F000000, 1'b1},
      '{32'h7FFFFFFF, 1'b0, 1'b1, 32'h4EFFFFFF, 1'b1},
      '{32'h02000003, 1'b0, 1'b0, 32'h4C000001, 1'b1},
      '{32'h02000003, 1'b0, 1'b1, 32'h4C000000, 1'b1}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_vec(v[i].x, v[i].u, v[i].r, yo, ixo, lat);
      checks++;
      if (lat != NS - 1 || yo !== v[i].y || ixo !== v[i].ix) begin
        errors++;
        $display("FAIL round_%0d x=%h rm=%b: y=%h ix=%b lat=%0d required %h %b %0d",
                 i, v[i].x, v[i].r, yo, ixo, lat, v[i].y, v[i].ix, NS - 1);
      end
    end
  endtask

  task automatic test_sign_mode;
    vec_t v [9];
    logic [31:0] yo;
    logic ixo;
    int lat;
    v = '{
      '{32'hFFFFFFFF, 1'b0, 1'b0, 32'hBF800000, 1'b0},
      '{32'hFFFFFFFF, 1'b1, 1'b0, 32'h4F800000, 1'b1},
      '{32'hFFFFFFFF, 1'b1, 1'b1, 32'h4F7FFFFF, 1'b1},
      '{32'h80000000, 1'b0, 1'b0, 32'hCF000000, 1'b0},
      '{32'h80000000, 1'b1, 1'b0, 32'h4F000000, 1'b0},
      '{32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0},
      '{32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b0},
      '{32'hFEFFFFFF, 1'b0, 1'b0, 32'hCB800000, 1'b1},
      '{32'hFEFFFFFD, 1'b0, 1'b0, 32'hCB800002, 1'b1}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_vec(v[i].x, v[i].u, v[i].r, yo, ixo, lat);
      checks++;
      if (lat != NS - 1 || yo !== v[i].y || ixo !== v[i].ix) begin
        errors++;
        $display("FAIL sign_%0d x=%h uns=%b rm=%b: y=%h ix=%b lat=%0d required %h %b %0d",
                 i, v[i].x, v[i].u, v[i].r, yo, ixo, lat, v[i].y, v[i].ix, NS - 1);
      end
    end
  endtask

  // Stream 1..10 back to back while out_ready cycles 1,0,0,1.
  task automatic test_back_to_back;
    logic [31:0] exp_q[$];
    logic [31:0] tbl [10];
    logic [3:0]  pat;
    int sent;
    int got;
    int cyc;
    logic holding;
    logic [31:0] held_y;
    logic [31:0] e;
    logic ir_bad;
    logic hold_bad;
    tbl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
    pat = 4'b1001;
    sent = 0;
    got = 0;
    cyc = 0;
    holding = 1'b0;
    held_y = 32'h0;
    ir_bad = 1'b0;
    hold_bad = 1'b0;
    uns = 1'b0;
    rm = 1'b0;
    while ((sent < 10 || got < 10) && cyc < 200) begin
      out_ready = pat[3 - (cyc % 4)];
      in_valid = (sent < 10);
      x = 32'(sent + 1);
      #1;
      if (in_ready !== (!out_valid || out_ready)) ir_bad = 1'b1;
      if (holding && (out_valid !== 1'b1 || y !== held_y)) hold_bad = 1'b1;
      if (in_valid && in_ready) begin
        exp_q.push_back(tbl[sent]);
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected output y=%h", y);
        end else begin
          e = exp_q.pop_front();
          if (y !== e || inexact !== 1'b0) begin
            errors++;
            $display("FAIL b2b_out_%0d: y=%h ix=%b required %h 0", got, y, inexact, e);
          end
        end
        got++;
      end
      holding = out_valid && !out_ready;
      held_y = y;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 10 || sent != 10) begin
      errors++;
      $display("FAIL b2b_count: sent=%0d received=%0d required 10 10", sent, got);
    end
    checks++;
    if (ir_bad) begin
      errors++;
      $display("FAIL b2b_in_ready: in_ready differed from ~out_valid|out_ready, required match");
    end
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL b2b_hold: y or out_valid changed while stalled, required stable");
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_midstream;
    logic stale;
    out_ready = 1'b1;
    uns = 1'b0;
    rm = 1'b0;
    for (int i = 0; i < NS; i++) begin
      in_valid = 1'b1;
      x = 32'(i + 5);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: out_valid=%b required 1", out_valid);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (ov_a[1] !== 1'b0 || ov_a[2] !== 1'b0 || ov_a[3] !== 1'b0 || ov_a[4] !== 1'b0
        || y !== 32'h0 || inexact !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: ov=%b%b%b%b y=%h ix=%b required 0000 00000000 0",
               ov_a[1], ov_a[2], ov_a[3], ov_a[4], y, inexact);
    end
    @(negedge clk);
    rstn = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int n = 1; n <= 4; n++) if (ov_a[n] !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL midreset_stale: out_valid rose after release, required 0");
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_sign_mode();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
